// File: rtl/linear_pkg.sv
// linear_pkg
//   Shared definitions for the linear engine result path: data/address
//   widths, location and size of the linear output region inside mem_w,
//   and the result reader state encoding.
package linear_pkg;

   localparam int DATA_W             = 64;
   localparam int ADDR_W             = 32;
   localparam int LINEAR_OUTPUT_BASE = 2048;
   localparam int LINEAR_OUTPUT_LEN  = 512;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/sync_fifo_sa.sv
// sync_fifo_sa
//   Show-ahead synchronous FIFO. The head entry is visible on pop_data_o
//   whenever the FIFO is non-empty; pop_i consumes it.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     push_i        write push_data_i (ignored when full unless popping)
//     push_data_i   write data
//     pop_i         consume the head entry (ignored when empty)
//     pop_data_o    head entry, forced to 0 while empty
//     empty_o       no entries stored
//     count_o       number of stored entries, 0..DEPTH
module sync_fifo_sa #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [W-1:0]             push_data_i,
   input  logic                     pop_i,
   output logic [W-1:0]             pop_data_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_push = push_i && ((count_q != FULL_C) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; stale contents are never visible because
   // the head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/linear_result_reader.sv
// linear_result_reader
//   Streams the linear output region (LEN words from word address BASE)
//   out of mem_w on a valid/ready interface. Reads are credit-limited so
//   the output FIFO can never overflow, which hides the 1-cycle memory
//   latency and absorbs consumer backpressure without re-reading.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     start               level request, sampled only in IDLE
//     busy, done          high in READ/DRAIN, high in DONE
//     write_en, data_in   memory write side, tied off (read-only client)
//     addr, data_out      memory address / read data (data 1 cycle later)
//     m_valid, m_data     stream word and its qualifier
//     m_last              marks word index LEN-1
//     m_ready             consumer accept
module linear_result_reader #(
   parameter int DATA_W     = linear_pkg::DATA_W,
   parameter int ADDR_W     = linear_pkg::ADDR_W,
   parameter int BASE       = linear_pkg::LINEAR_OUTPUT_BASE,
   parameter int LEN        = linear_pkg::LINEAR_OUTPUT_LEN,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              write_en,
   output logic [DATA_W-1:0] data_in,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_out,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready
);

   import linear_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [16:0]       LEN_C   = 17'(LEN);
   localparam logic [16:0]       LAST_C  = 17'(LEN - 1);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);
   localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

   state_t            state_q, state_d;
   logic [16:0]       issued_q, issued_d;
   logic [16:0]       out_cnt_q, out_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              inflight_q;

   logic              rd_issue;
   logic              credit_ok;
   logic              pop;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   // A read in flight already owns a FIFO slot, so it counts as a credit.
   assign credit_ok = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q}) < DEPTH_C;
   assign rd_issue  = (state_q == READ) && (issued_q < LEN_C) && credit_ok;
   assign pop       = m_valid && m_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         issued_q   <= '0;
         out_cnt_q  <= '0;
         addr_q     <= BASE_C;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         issued_q   <= issued_d;
         out_cnt_q  <= out_cnt_d;
         addr_q     <= addr_d;
         inflight_q <= rd_issue;
      end
   end

   always_comb begin
      state_d   = state_q;
      issued_d  = issued_q;
      out_cnt_d = out_cnt_q;
      addr_d    = addr_q;

      if (pop) out_cnt_d = out_cnt_q + 17'd1;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = READ;
               issued_d  = '0;
               out_cnt_d = '0;
               addr_d    = BASE_C;
            end
         end
         READ: begin
            if (rd_issue) begin
               issued_d = issued_q + 17'd1;
               // The final read leaves addr on the last word of the region
               // instead of stepping one past it.
               if (issued_q == LAST_C) state_d = DRAIN;
               else                    addr_d  = addr_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
            if (!inflight_q && fifo_empty && (out_cnt_q == LEN_C)) state_d = DONE;
         end
         DONE: begin
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   sync_fifo_sa #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_data_i (data_out),
      .pop_i       (pop),
      .pop_data_o  (m_data),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign busy     = (state_q == READ) || (state_q == DRAIN);
   assign done     = (state_q == DONE);
   assign write_en = 1'b0;
   assign data_in  = '0;
   assign addr     = addr_q;
   assign m_valid  = !fifo_empty;
   assign m_last   = m_valid && (out_cnt_q == LAST_C);

endmodule
